// File: rtl/m92_pkg.sv
// Shared types and constants for the M92 main-CPU bus sequencing logic.
package m92_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SDR_WAIT,
    PAUSED,
    RESYNC
  } cpu_bus_state_t;

  localparam int CPU_CE_DIV = 4;

endpackage

// File: rtl/m92_cpu_bus_ctrl.sv
// V30 bus sequencer: CPU clock enables, strobe stretching, single-outstanding SDRAM
// channel and raster-locked pause/resume. Handshake: sdr_req is a 1-cycle pulse, sdr_rdy a 1-cycle completion.
module m92_cpu_bus_ctrl
  import m92_pkg::*;
#(
  parameter int CE_DIV = CPU_CE_DIV,
  parameter int H_W    = 10,
  parameter int V_W    = 9
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  input  logic           bus_read,
  input  logic           bus_write,
  input  logic [1:0]     bus_be,
  input  logic [19:0]    bus_addr,
  input  logic [15:0]    bus_dout,
  input  logic           ram_rom_memrq,
  input  logic           pf_vram_memrq,
  input  logic [24:0]    region_addr,
  input  logic           region_writable,
  input  logic           ext_busy,
  input  logic           pause_rq,
  input  logic [H_W-1:0] h,
  input  logic [V_W-1:0] v,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ce_cpu,
  output logic           ce_4x_cpu,
  output logic           paused,
  output logic [24:0]    sdr_addr,
  output logic [15:0]    sdr_din,
  output logic [1:0]     sdr_wr_sel,
  output logic           sdr_req,
  input  logic           sdr_rdy,
  input  logic [15:0]    sdr_dout,
  output logic [15:0]    rom_data
);

  localparam int CNT_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CE_DIV - 1);

  cpu_bus_state_t r_state;
  cpu_bus_state_t w_state_nxt;

  logic             r_read_d1;
  logic             r_write_d1;
  logic [CNT_W-1:0] r_ce_cnt;
  logic [H_W-1:0]   r_ph;
  logic [V_W-1:0]   r_pv;
  logic [24:0]      r_sdr_addr;
  logic [15:0]      r_sdr_din;
  logic [1:0]       r_sdr_wr_sel;
  logic             r_sdr_req;
  logic [15:0]      r_rom_data;

  logic w_new_rd;
  logic w_new_wr;
  logic w_new_acc;
  logic w_pause_go;
  logic w_ce_4x;
  logic w_unused;

  // Only the byte-lane bit of the CPU address matters here; translation happens upstream.
  assign w_unused = ^bus_addr[19:1];

  assign w_new_rd   = bus_read & ~r_read_d1;
  assign w_new_wr   = bus_write & ~r_write_d1;
  assign w_new_acc  = (r_state == IDLE) & ram_rom_memrq & (w_new_rd | w_new_wr);

  assign mem_read   = bus_read | r_read_d1;
  assign mem_write  = bus_write | r_write_d1;
  assign w_pause_go = pause_rq & ~mem_read & ~mem_write & ~w_new_acc;

  assign paused     = (r_state == PAUSED) | (r_state == RESYNC);

  // A memory-mapped access in flight holds the CPU until the target has had a chance to stall it.
  assign w_ce_4x = reset_n & (r_state == IDLE) & ~paused & ~ext_busy &
                   ~((ram_rom_memrq | pf_vram_memrq) & (mem_read | mem_write));

  assign ce_4x_cpu  = w_ce_4x;
  assign ce_cpu     = w_ce_4x & (r_ce_cnt == CNT_LAST);

  assign sdr_addr   = r_sdr_addr;
  assign sdr_din    = r_sdr_din;
  assign sdr_wr_sel = r_sdr_wr_sel;
  assign sdr_req    = r_sdr_req;
  assign rom_data   = r_rom_data;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_new_acc) begin
          w_state_nxt = SDR_WAIT;
        end else if (w_pause_go) begin
          w_state_nxt = PAUSED;
        end
      end
      SDR_WAIT: begin
        if (sdr_rdy) begin
          w_state_nxt = IDLE;
        end
      end
      PAUSED: begin
        if (!pause_rq) begin
          w_state_nxt = RESYNC;
        end
      end
      RESYNC: begin
        if ((h == r_ph) && (v == r_pv)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_read_d1    <= 1'b0;
      r_write_d1   <= 1'b0;
      r_ce_cnt     <= '0;
      r_ph         <= '0;
      r_pv         <= '0;
      r_sdr_addr   <= '0;
      r_sdr_din    <= '0;
      r_sdr_wr_sel <= 2'b00;
      r_sdr_req    <= 1'b0;
      r_rom_data   <= '0;
    end else begin
      r_read_d1  <= bus_read;
      r_write_d1 <= bus_write;
      r_sdr_req  <= w_new_acc;

      if (w_new_acc) begin
        r_sdr_addr <= region_addr;
        // Odd byte writes move the low data byte onto the high SDRAM lane.
        if (w_new_wr && region_writable) begin
          r_sdr_wr_sel <= bus_addr[0] ? {bus_be[0], 1'b0} : bus_be;
          r_sdr_din    <= bus_addr[0] ? {bus_dout[7:0], 8'h00} : bus_dout;
        end else begin
          r_sdr_wr_sel <= 2'b00;
        end
      end

      if ((r_state == SDR_WAIT) && sdr_rdy) begin
        r_rom_data <= sdr_dout;
      end

      if (w_ce_4x) begin
        r_ce_cnt <= (r_ce_cnt == CNT_LAST) ? '0 : r_ce_cnt + CNT_W'(1);
      end

      if ((r_state == IDLE) && w_pause_go) begin
        r_ph <= h;
        r_pv <= v;
      end
    end
  end

endmodule

// File: tb/tb_m92_cpu_bus_ctrl.sv
// Self-checking bench for m92_cpu_bus_ctrl: SDRAM request scoreboard, clock-enable cadence,
// raster-locked pause/resume and reset during an outstanding request.
module tb_m92_cpu_bus_ctrl;

  localparam int H_W   = 10;
  localparam int V_W   = 9;
  localparam int H_TOT = 128;
  localparam int V_TOT = 64;
  localparam int REQ_W = 44;

  logic           clk_sys = 1'b0;
  logic           reset_n;
  logic           bus_read, bus_write;
  logic [1:0]     bus_be;
  logic [19:0]    bus_addr;
  logic [15:0]    bus_dout;
  logic           ram_rom_memrq, pf_vram_memrq;
  logic [24:0]    region_addr;
  logic           region_writable;
  logic           ext_busy, pause_rq;
  logic [H_W-1:0] h = '0;
  logic [V_W-1:0] v = '0;
  logic           mem_read, mem_write, ce_cpu, ce_4x_cpu, paused;
  logic [24:0]    sdr_addr;
  logic [15:0]    sdr_din;
  logic [1:0]     sdr_wr_sel;
  logic           sdr_req, sdr_rdy;
  logic [15:0]    sdr_dout;
  logic [15:0]    rom_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_req    = 0;

  // {din_valid, addr, wr_sel, din}
  logic [REQ_W-1:0] exp_q[$];

  m92_cpu_bus_ctrl dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .bus_read(bus_read), .bus_write(bus_write), .bus_be(bus_be),
    .bus_addr(bus_addr), .bus_dout(bus_dout),
    .ram_rom_memrq(ram_rom_memrq), .pf_vram_memrq(pf_vram_memrq),
    .region_addr(region_addr), .region_writable(region_writable),
    .ext_busy(ext_busy), .pause_rq(pause_rq), .h(h), .v(v),
    .mem_read(mem_read), .mem_write(mem_write), .ce_cpu(ce_cpu),
    .ce_4x_cpu(ce_4x_cpu), .paused(paused),
    .sdr_addr(sdr_addr), .sdr_din(sdr_din), .sdr_wr_sel(sdr_wr_sel),
    .sdr_req(sdr_req), .sdr_rdy(sdr_rdy), .sdr_dout(sdr_dout),
    .rom_data(rom_data)
  );

  // ---------------- clock / raster ----------------
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    #1;
    if (h == H_W'(H_TOT - 1)) begin
      h = '0;
      v = (v == V_W'(V_TOT - 1)) ? '0 : v + V_W'(1);
    end else begin
      h = h + H_W'(1);
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic mid();
    @(negedge clk_sys);
  endtask

  // ---------------- request scoreboard ----------------
  always @(negedge clk_sys) begin
    logic [REQ_W-1:0] e;
    if (sdr_req !== 1'b0) begin
      n_req++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_req: addr=%h wr_sel=%b expected no request", sdr_addr, sdr_wr_sel);
      end else begin
        e = exp_q.pop_front();
        if (sdr_addr !== e[42:18] || sdr_wr_sel !== e[17:16] || (e[43] && sdr_din !== e[15:0]))
          $display("FAIL req_fields: addr=%h wr_sel=%b din=%h expected addr=%h wr_sel=%b din=%h(valid=%b)",
                   sdr_addr, sdr_wr_sel, sdr_din, e[42:18], e[17:16], e[15:0], e[43]);
        else n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_access(input bit wr, input logic [19:0] a, input logic [1:0] be,
                           input logic [15:0] d, input bit wrt, input logic [24:0] ra,
                           input int dly, input logic [15:0] rd, input string nm);
    int          req0;
    logic [1:0]  sel;
    logic [15:0] din;
    bit          dv;
    bit          stall_bad;
    dv  = wr && wrt;
    sel = dv ? (a[0] ? {be[0], 1'b0} : be) : 2'b00;
    din = a[0] ? {d[7:0], 8'h00} : d;
    req0 = n_req;
    stall_bad = 0;

    tick();
    bus_read = !wr; bus_write = wr; bus_addr = a; bus_be = be; bus_dout = d;
    region_addr = ra; region_writable = wrt; ram_rom_memrq = 1'b1;
    exp_q.push_back({dv, ra, sel, din});
    mid();
    if (ce_4x_cpu !== 1'b0) stall_bad = 1;
    tick();
    bus_read = 0; bus_write = 0;
    mid();
    n_checks++;
    if ((wr ? mem_write : mem_read) !== 1'b1)
      $display("FAIL %s_stretch: strobe=%b expected 1", nm, wr ? mem_write : mem_read);
    else n_pass++;
    if (ce_4x_cpu !== 1'b0) stall_bad = 1;
    for (int i = 0; i < dly; i++) begin
      tick();
      mid();
      if (ce_4x_cpu !== 1'b0) stall_bad = 1;
    end
    tick();
    sdr_rdy = 1; sdr_dout = rd;
    mid();
    if (ce_4x_cpu !== 1'b0) stall_bad = 1;
    tick();
    sdr_rdy = 0; sdr_dout = 16'h0000;
    mid();
    n_checks++;
    if (stall_bad) $display("FAIL %s_stall: ce_4x_cpu pulsed during access expected 0", nm);
    else n_pass++;
    n_checks++;
    if (ce_4x_cpu !== 1'b1) $display("FAIL %s_resume: ce_4x_cpu=%b expected 1", nm, ce_4x_cpu);
    else n_pass++;
    n_checks++;
    if (rom_data !== rd) $display("FAIL %s_rom_data: got %h expected %h", nm, rom_data, rd);
    else n_pass++;
    n_checks++;
    if (n_req - req0 != 1) $display("FAIL %s_req_count: got %0d expected 1", nm, n_req - req0);
    else n_pass++;
    ram_rom_memrq = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 0;
    repeat (3) tick();
    mid();
    n_checks++;
    if ({ce_4x_cpu, ce_cpu, paused, sdr_req, mem_read, mem_write} !== 6'b0 ||
        sdr_addr !== '0 || sdr_din !== '0 || sdr_wr_sel !== 2'b00 || rom_data !== '0)
      $display("FAIL reset_outputs: ce4x=%b ce=%b paused=%b req=%b addr=%h din=%h sel=%b rom=%h expected all 0",
               ce_4x_cpu, ce_cpu, paused, sdr_req, sdr_addr, sdr_din, sdr_wr_sel, rom_data);
    else n_pass++;
    tick();
    reset_n = 1;
  endtask

  task automatic test_read();
    do_access(0, 20'h01234, 2'b11, 16'h0000, 1, 25'h0A01234, 4, 16'hBEEF, "read");
  endtask

  task automatic test_write_odd();
    do_access(1, 20'h00101, 2'b01, 16'h0012, 1, 25'h0100101, 2, 16'h5555, "write_odd");
  endtask

  task automatic test_write_even();
    do_access(1, 20'h00200, 2'b11, 16'hABCD, 1, 25'h0100200, 1, 16'h3C3C, "write_even");
  endtask

  task automatic test_write_rom();
    do_access(1, 20'h00033, 2'b10, 16'h9876, 0, 25'h0000033, 3, 16'hA5A5, "write_rom");
  endtask

  task automatic test_ce_idle();
    int n4, ncpu, last_idx, since, k;
    bit gap_bad, busy_bad, found;
    n4 = 0; ncpu = 0; last_idx = -1; since = 0; gap_bad = 0; busy_bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      mid();
      if (ce_4x_cpu === 1'b1) n4++;
      if (ce_cpu === 1'b1) begin
        ncpu++;
        if (ce_4x_cpu !== 1'b1 || (last_idx >= 0 && i - last_idx != 4)) gap_bad = 1;
        last_idx = i;
        since = 0;
      end else if (ce_4x_cpu === 1'b1) begin
        since++;
      end
    end
    n_checks++;
    if (n4 != 16) $display("FAIL ce4x_count: got %0d expected 16", n4); else n_pass++;
    n_checks++;
    if (ncpu != 4) $display("FAIL ce_cpu_count: got %0d expected 4", ncpu); else n_pass++;
    n_checks++;
    if (gap_bad) $display("FAIL ce_cpu_spacing: irregular spacing expected every 4th"); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) ext_busy = 1;
      mid();
      if (ce_4x_cpu !== 1'b0 || ce_cpu !== 1'b0) busy_bad = 1;
    end
    n_checks++;
    if (busy_bad) $display("FAIL ext_busy_freeze: ce pulsed while busy expected none"); else n_pass++;
    tick();
    ext_busy = 0;
    k = 0; found = 0;
    for (int i = 0; i < 8; i++) begin
      mid();
      if (ce_4x_cpu === 1'b1) k++;
      if (ce_cpu === 1'b1) begin found = 1; break; end
      tick();
    end
    n_checks++;
    if (!found || k != 4 - since)
      $display("FAIL ce_phase_hold: ce_cpu after %0d pulses (found=%0d) expected %0d", k, found, 4 - since);
    else n_pass++;
  endtask

  task automatic test_pause();
    bit found, bad, rfound, fp;
    logic [H_W-1:0] fh;
    logic [V_W-1:0] fv;
    found = 0; bad = 0; rfound = 0; fp = 1; fh = '0; fv = '0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (h == H_W'(100) && v == V_W'(50)) begin found = 1; break; end
    end
    n_checks++;
    if (!found) $display("FAIL pause_reach_pos: h=%0d v=%0d expected 100/50", h, v); else n_pass++;
    pause_rq = 1;
    tick();
    mid();
    n_checks++;
    if (paused !== 1'b1 || ce_4x_cpu !== 1'b0)
      $display("FAIL pause_enter: paused=%b ce4x=%b expected 1/0", paused, ce_4x_cpu);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      tick();
      mid();
      if (ce_4x_cpu !== 1'b0 || ce_cpu !== 1'b0 || paused !== 1'b1) bad = 1;
    end
    tick();
    pause_rq = 0;
    for (int i = 0; i < 9000; i++) begin
      mid();
      if (ce_4x_cpu === 1'b1) begin rfound = 1; fh = h; fv = v; fp = paused; break; end
      if (paused !== 1'b1) bad = 1;
      tick();
    end
    n_checks++;
    if (bad) $display("FAIL pause_hold: ce or paused wrong while paused expected frozen"); else n_pass++;
    n_checks++;
    if (!rfound || fh !== H_W'(101) || fv !== V_W'(50) || fp !== 1'b0)
      $display("FAIL pause_resume_pos: found=%0d h=%0d v=%0d paused=%b expected 101/50/0", rfound, fh, fv, fp);
    else n_pass++;
  endtask

  task automatic test_pause_vs_access();
    tick();
    bus_read = 1; bus_addr = 20'h00400; bus_be = 2'b11; ram_rom_memrq = 1;
    region_addr = 25'h0000400; region_writable = 1; pause_rq = 1;
    exp_q.push_back({1'b0, 25'h0000400, 2'b00, 16'h0000});
    tick();
    bus_read = 0;
    mid();
    n_checks++;
    if (paused !== 1'b0) $display("FAIL access_beats_pause: paused=%b expected 0", paused); else n_pass++;
    tick();
    mid();
    n_checks++;
    if (paused !== 1'b0) $display("FAIL pause_ignored_in_wait: paused=%b expected 0", paused); else n_pass++;
    tick();
    sdr_rdy = 1; sdr_dout = 16'h7777;
    tick();
    sdr_rdy = 0; sdr_dout = 16'h0000; ram_rom_memrq = 0;
    mid();
    n_checks++;
    if (rom_data !== 16'h7777) $display("FAIL pva_rom_data: got %h expected 7777", rom_data); else n_pass++;
    tick();
    mid();
    n_checks++;
    if (paused !== 1'b1) $display("FAIL pause_after_access: paused=%b expected 1", paused); else n_pass++;
    pause_rq = 0;
  endtask

  task automatic test_reset_mid_wait();
    int req0;
    bit req_bad;
    req_bad = 0;
    tick();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
    tick();
    bus_read = 1; bus_addr = 20'h00500; ram_rom_memrq = 1; region_addr = 25'h0000500;
    exp_q.push_back({1'b0, 25'h0000500, 2'b00, 16'h0000});
    tick();
    bus_read = 0;
    tick();
    ram_rom_memrq = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
    mid();
    req0 = n_req;
    tick();
    sdr_rdy = 1; sdr_dout = 16'h1111;
    tick();
    sdr_rdy = 0; sdr_dout = 16'h0000;
    mid();
    n_checks++;
    if (rom_data !== 16'h0000) $display("FAIL stray_rdy_rom_data: got %h expected 0000", rom_data); else n_pass++;
    n_checks++;
    if (paused !== 1'b0 || ce_4x_cpu !== 1'b1)
      $display("FAIL reset_wait_idle: paused=%b ce4x=%b expected 0/1", paused, ce_4x_cpu);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      mid();
      if (sdr_req !== 1'b0) req_bad = 1;
    end
    n_checks++;
    if (req_bad || n_req != req0) $display("FAIL stray_rdy_no_req: reqs=%0d expected 0", n_req - req0);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n = 0; bus_read = 0; bus_write = 0; bus_be = 2'b00; bus_addr = '0; bus_dout = '0;
    ram_rom_memrq = 0; pf_vram_memrq = 0; region_addr = '0; region_writable = 0;
    ext_busy = 0; pause_rq = 0; sdr_rdy = 0; sdr_dout = '0;

    test_reset();
    test_read();
    test_write_odd();
    test_write_even();
    test_write_rom();
    test_ce_idle();
    test_pause();
    test_pause_vs_access();
    test_reset_mid_wait();

    repeat (2) tick();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL req_queue_drain: %0d pending expected 0", exp_q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
